// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine feeding the HI and LO registers.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up before the write pulse.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             hiWrite,
    output logic             loWrite,
    output logic [WIDTH-1:0] hiData,
    output logic [WIDTH-1:0] loData,
    output logic             divByZero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_reg;
    logic [CW-1:0]      count_reg;
    logic               is_div_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic               b_zero_reg;
    logic               done_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   a_raw_reg;
    logic [WIDTH-1:0]   hi_data_reg;
    logic [WIDTH-1:0]   lo_data_reg;
    logic [2*WIDTH-1:0] acc_reg;

    // op[0]=1 selects the unsigned variant; op[1]=1 selects divide
    logic             is_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign is_signed = ~op[0];
    assign abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiply: accumulator is {partial_hi, multiplier}; add into the top, shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: accumulator is {rem, quo}; the shifted remainder needs one extra bit.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_fits = (rem_sh >= {1'b0, opnd_reg});
    assign rem_diff = rem_sh[WIDTH-1:0] - opnd_reg;
    assign div_next = div_fits ? {rem_diff, acc_reg[WIDTH-2:0], 1'b1}
                               : {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [2*WIDTH-1:0] prod_neg;

    assign prod_neg = ~acc_reg + 1'b1;

    always_comb begin
        fix_hi = acc_reg[2*WIDTH-1:WIDTH];
        fix_lo = acc_reg[WIDTH-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                fix_hi = a_raw_reg;
                fix_lo = '1;
            end else begin
                if (neg_res_reg) fix_lo = ~acc_reg[WIDTH-1:0] + 1'b1;
                if (neg_rem_reg) fix_hi = ~acc_reg[2*WIDTH-1:WIDTH] + 1'b1;
            end
        end else if (neg_res_reg) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            b_zero_reg   <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            opnd_reg     <= '0;
            a_raw_reg    <= '0;
            hi_data_reg  <= '0;
            lo_data_reg  <= '0;
            acc_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        is_div_reg   <= op[1];
                        neg_res_reg  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_reg  <= is_signed & a[WIDTH-1];
                        b_zero_reg   <= (b == '0);
                        a_raw_reg    <= a;
                        opnd_reg     <= op[1] ? abs_b : abs_a;
                        acc_reg      <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        count_reg    <= '0;
                        div_zero_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg   <= is_div_reg ? div_next : mul_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == CW'(WIDTH - 1)) state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else begin
                        hi_data_reg  <= fix_hi;
                        lo_data_reg  <= fix_lo;
                        div_zero_reg <= is_div_reg & b_zero_reg;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign hiWrite   = done_reg;
    assign loWrite   = done_reg;
    assign hiData    = hi_data_reg;
    assign loData    = lo_data_reg;
    assign divByZero = div_zero_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO/flag,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, hiWrite, loWrite, divByZero;
    logic [W-1:0] hiData, loData;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .busy(busy), .done(done), .hiWrite(hiWrite), .loWrite(loWrite),
        .hiData(hiData), .loData(loData), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   issued = 0;
    bit   prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one result line per done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (done === 1'b1) begin
                exp_t e;
                pulses++;
                if (prev_done) check("done_width", 64'(prev_done), 64'd0);
                check("write_strobes", {62'd0, hiWrite, loWrite}, 64'd3);
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, {hiData, loData}, {e.hi, e.lo});
                    check({e.name, "_dbz"}, 64'(divByZero), 64'(e.dbz));
                    $display("op %-10s hi=%h lo=%h dbz=%0d", e.name, hiData, loData, divByZero);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // mode 1 injects a stray start at CALC cycle 5
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                          input string name, input int mode);
        exp_t e;
        int   n;
        e.hi = eh; e.lo = el; e.dbz = ed; e.name = name;
        sb.push_back(e);
        issued++;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            start = (mode == 1 && n == 5);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        // done visible after edge E0+33; HI/LO latch the write on edge E0+34
        check({name, "_latency"}, 64'(n), 64'(W + 1));
        @(posedge clk); #1;
        check({name, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {59'd0, busy, done, hiWrite, loWrite, divByZero}, 64'd0);
        check("reset_data", {hiData, loData}, 64'd0);
        rst_n = 1'b1;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max", 0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg", 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg", 0);
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu", 0);
        run_op(2'b11, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1, "divu_zero", 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, "div_ovf", 0);
        run_op(2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0, "mult_min", 0);
        run_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_negb", 0);
        run_op(2'b01, 32'd5,        32'd6,        32'd0,        32'd30,       1'b0, "busy_start", 1);

        // abort together with start in IDLE drops the request
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'd0);

        // abort at CALC cycle 10: no write, prior result held
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("calc_abort_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1 check("abort_hold", {hiData, loData}, {32'd0, 32'd30});

        // async reset mid-CALC clears outputs immediately
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd11; b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {27'd0, busy, done, divByZero, hiData != 0, loData != 0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "after_reset", 0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("done_pulses", 64'(pulses), 64'(issued));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
